// File: rtl/img_ram_gray_reader.sv
// img_ram_gray_reader: scans the 24-bit pixel RAM, converts each pixel to 8-bit luma
// and streams it on valid/ready. Build option IMG_THRESH_EN adds thresh[7:0] and binarises the output.
module img_ram_gray_reader #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 24,
  parameter int NUM_PIX = 41750,
  parameter int FIFO_D  = 4
) (
  input  logic              clka,
  input  logic              rsta,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              ram_ena,
  output logic              ram_wea,
  output logic [ADDR_W-1:0] ram_addra,
  input  logic [DATA_W-1:0] ram_douta,
`ifdef IMG_THRESH_EN
  input  logic [7:0]        thresh,
`endif
  output logic              m_valid,
  input  logic              m_ready,
  output logic [7:0]        m_gray,
  output logic              m_last
);

  // state   | meaning
  // S_IDLE  | waiting for start
  // S_RUN   | issuing reads 0..NUM_PIX-1 while the buffer has room
  // S_DRAIN | all reads issued, waiting for the last beat to be accepted
  // S_DONE  | one-cycle done pulse

  localparam int PTR_W = (FIFO_D > 1) ? $clog2(FIFO_D) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIX - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] last_addr;
  logic              rd_pend;
  logic              rd_last;
  logic              issue;
  logic              push;
  logic              pop;
  logic [CNT_W-1:0]  count;
  logic [CNT_W:0]    occ_sum;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [8:0]        mem [FIFO_D];
  logic [15:0]       acc;
  logic [7:0]        luma;
  logic [7:0]        pix_val;

  // Credit only what is already buffered or returning; a pop this cycle is not counted.
  assign occ_sum = {1'b0, count} + {{CNT_W{1'b0}}, rd_pend};
  assign issue   = (state == S_RUN) && (occ_sum < (CNT_W+1)'(FIFO_D));
  assign push    = rd_pend;
  assign pop     = m_valid & m_ready;

  always_ff @(posedge clka or posedge rsta) begin
    if (rsta) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (issue && (addr == LAST_ADDR)) state_nxt = S_DRAIN;
      S_DRAIN: if (pop && m_last) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy    = 1'b0;
    done    = 1'b0;
    ram_ena = 1'b0;
    unique case (state)
      S_RUN: begin
        busy    = 1'b1;
        ram_ena = issue;
      end
      S_DRAIN: busy = 1'b1;
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  assign ram_wea   = 1'b0;
  assign ram_addra = ram_ena ? addr : last_addr;

  always_ff @(posedge clka or posedge rsta) begin
    if (rsta) begin
      addr      <= '0;
      last_addr <= '0;
      rd_pend   <= 1'b0;
      rd_last   <= 1'b0;
    end else begin
      rd_pend <= issue;
      rd_last <= issue && (addr == LAST_ADDR);
      if ((state == S_IDLE) && start) begin
        addr <= '0;
      end else if (issue) begin
        last_addr <= addr;
        if (addr != LAST_ADDR) addr <= addr + 1'b1;
      end
    end
  end

  // Max sum is 255*256 = 65280, so 16 bits never overflow.
  assign acc  = 16'd77  * 16'(ram_douta[23:16])
              + 16'd150 * 16'(ram_douta[15:8])
              + 16'd29  * 16'(ram_douta[7:0]);
  assign luma = 8'(acc >> 8);

`ifdef IMG_THRESH_EN
  assign pix_val = (luma >= thresh) ? 8'hFF : 8'h00;
`else
  assign pix_val = luma;
`endif

  always_ff @(posedge clka) begin
    if (push) mem[wr_ptr] <= {rd_last, pix_val};
  end

  always_ff @(posedge clka or posedge rsta) begin
    if (rsta) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Head is gated so outputs read 0 while empty (including straight out of reset).
  assign m_valid = (count != '0);
  assign m_gray  = m_valid ? mem[rd_ptr][7:0] : 8'h00;
  assign m_last  = m_valid & mem[rd_ptr][8];

endmodule

// File: tb/tb_img_ram_gray_reader.sv
// Bench for img_ram_gray_reader: three instances (NUM_PIX 4/16/64) with RAM models and an expected-beat queue.
`timescale 1ns/1ps
module tb_img_ram_gray_reader;
  localparam int NI = 3;

  logic        clka = 1'b0;
  logic        rsta;
  logic        start     [NI];
  logic        m_ready   [NI];
  logic        busy      [NI];
  logic        done      [NI];
  logic        ram_ena   [NI];
  logic        ram_wea   [NI];
  logic        m_valid   [NI];
  logic        m_last    [NI];
  logic [15:0] ram_addra [NI];
  logic [23:0] ram_douta [NI];
  logic [7:0]  m_gray    [NI];
  logic [23:0] ram       [NI][64];
`ifdef IMG_THRESH_EN
  logic [7:0]  thresh = 8'd100;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [8:0] sb [$];

  always #5 clka = ~clka;

  for (genvar k = 0; k < NI; k++) begin : g_dut
    img_ram_gray_reader #(
      .ADDR_W (16),
      .DATA_W (24),
      .NUM_PIX((k == 0) ? 4 : ((k == 1) ? 16 : 64)),
      .FIFO_D (4)
    ) u_dut (
      .clka     (clka),
      .rsta     (rsta),
      .start    (start[k]),
      .busy     (busy[k]),
      .done     (done[k]),
      .ram_ena  (ram_ena[k]),
      .ram_wea  (ram_wea[k]),
      .ram_addra(ram_addra[k]),
      .ram_douta(ram_douta[k]),
`ifdef IMG_THRESH_EN
      .thresh   (thresh),
`endif
      .m_valid  (m_valid[k]),
      .m_ready  (m_ready[k]),
      .m_gray   (m_gray[k]),
      .m_last   (m_last[k])
    );

    always @(posedge clka) begin
      if (ram_ena[k]) ram_douta[k] <= ram[k][ram_addra[k][5:0]];
    end
  end

  function automatic logic [7:0] exp_pix(input logic [23:0] p);
    int y;
    y = (77 * int'(p[23:16]) + 150 * int'(p[15:8]) + 29 * int'(p[7:0])) / 256;
`ifdef IMG_THRESH_EN
    return (y >= int'(thresh)) ? 8'hFF : 8'h00;
`else
    return 8'(y);
`endif
  endfunction

  task automatic load_sb(input int k, input int n);
    sb.delete();
    for (int i = 0; i < n; i++) sb.push_back({(i == n - 1), exp_pix(ram[k][i])});
  endtask

  task automatic test_reset();
    bit seen;
    rsta = 1'b1;
    repeat (2) @(posedge clka);
    #1;
    for (int k = 0; k < NI; k++) begin
      n_checks++;
      if ({busy[k], done[k], ram_ena[k], ram_wea[k], ram_addra[k], m_valid[k], m_gray[k], m_last[k]} !== '0) begin
        n_fail++;
        $display("FAIL reset_state[%0d]: got busy=%b done=%b ena=%b wea=%b addr=%0d valid=%b gray=%0d last=%b, want all 0",
                 k, busy[k], done[k], ram_ena[k], ram_wea[k], ram_addra[k], m_valid[k], m_gray[k], m_last[k]);
      end
    end
    rsta = 1'b0;
    for (int i = 0; i < 16; i++) ram[1][i] = 24'h808080 | 24'(i);
    @(posedge clka); #1;
    m_ready[1] = 1'b0;
    start[1]   = 1'b1;
    @(posedge clka); #1;
    start[1] = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clka);
      seen = m_valid[1];
    end
    repeat (2) @(posedge clka);
    @(negedge clka); #2;
    n_checks++;
    if (!(busy[1] === 1'b1 && m_valid[1] === 1'b1 && m_gray[1] !== 8'h00 && ram_ena[1] === 1'b0 && ram_addra[1] === 16'd3)) begin
      n_fail++;
      $display("FAIL reset_pre_active: got busy=%b valid=%b gray=%0d ena=%b addr=%0d, want 1 1 nonzero 0 3",
               busy[1], m_valid[1], m_gray[1], ram_ena[1], ram_addra[1]);
    end
    rsta = 1'b1;
    #1;
    n_checks++;
    if ({busy[1], done[1], ram_ena[1], ram_wea[1], ram_addra[1], m_valid[1], m_gray[1], m_last[1]} !== '0) begin
      n_fail++;
      $display("FAIL reset_async: got busy=%b ena=%b addr=%0d valid=%b gray=%0d last=%b, want all 0",
               busy[1], ram_ena[1], ram_addra[1], m_valid[1], m_gray[1], m_last[1]);
    end
    @(posedge clka); #1;
    rsta = 1'b0;
  endtask

  task automatic test_basic();
    int first_v = -1, beats = 0, last_beat = -1, done_cyc = -1, n_done = 0, addr_exp = 0;
    logic [8:0] exp;
    ram[0][0] = 24'hFF0000; ram[0][1] = 24'h00FF00; ram[0][2] = 24'h0000FF; ram[0][3] = 24'hFFFFFF;
    load_sb(0, 4);
    @(posedge clka); #1;
    m_ready[0] = 1'b1;
    start[0]   = 1'b1;
    @(posedge clka); #1;
    start[0] = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clka);
      if (ram_ena[0]) begin
        n_checks++;
        if (ram_addra[0] !== 16'(addr_exp) || ram_wea[0] !== 1'b0) begin
          n_fail++;
          $display("FAIL basic_addr: got addr=%0d wea=%b, want addr=%0d wea=0", ram_addra[0], ram_wea[0], addr_exp);
        end
        addr_exp++;
      end
      if (m_valid[0] && first_v < 0) first_v = c;
      if (m_valid[0] && m_ready[0]) begin
        exp = (sb.size() > 0) ? sb.pop_front() : 9'h1xx;
        n_checks++;
        if ({m_last[0], m_gray[0]} !== exp) begin
          n_fail++;
          $display("FAIL basic_beat%0d: got last=%b gray=%0d, want last=%b gray=%0d", beats, m_last[0], m_gray[0], exp[8], exp[7:0]);
        end
        if (beats > 0) begin
          n_checks++;
          if (c != last_beat + 1) begin
            n_fail++;
            $display("FAIL basic_gap: beat%0d at cycle %0d, want cycle %0d", beats, c, last_beat + 1);
          end
        end
        last_beat = c;
        beats++;
      end
      if (done[0]) begin
        n_done++;
        done_cyc = c;
      end
    end
    n_checks++;
    if (first_v < 1 || first_v > 3) begin
      n_fail++;
      $display("FAIL basic_latency: first valid at cycle %0d, want 1..3", first_v);
    end
    n_checks++;
    if (beats != 4 || addr_exp != 4 || n_done != 1 || done_cyc != last_beat + 1) begin
      n_fail++;
      $display("FAIL basic_frame: got beats=%0d reads=%0d dones=%0d done_cyc=%0d, want 4 4 1 %0d",
               beats, addr_exp, n_done, done_cyc, last_beat + 1);
    end
  endtask

  task automatic test_backpressure();
    int reads = 0, stall_bad = 0, beats = 0, n_done = 0;
    bit seen = 1'b0;
    logic [8:0] held, exp;
    for (int i = 0; i < 16; i++) ram[1][i] = 24'($urandom);
    load_sb(1, 16);
    @(posedge clka); #1;
    m_ready[1] = 1'b0;
    start[1]   = 1'b1;
    @(posedge clka); #1;
    start[1] = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clka);
      if (ram_ena[1]) reads++;
      seen = m_valid[1];
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL bp_first_valid: got no m_valid within 10 cycles, want valid");
    end
    held = {m_last[1], m_gray[1]};
    n_checks++;
    if (held !== sb[0]) begin
      n_fail++;
      $display("FAIL bp_head: got last=%b gray=%0d, want last=%b gray=%0d", held[8], held[7:0], sb[0][8], sb[0][7:0]);
    end
    for (int c = 0; c < 10; c++) begin
      @(negedge clka);
      if (ram_ena[1]) reads++;
      if (m_valid[1] !== 1'b1 || {m_last[1], m_gray[1]} !== held) stall_bad++;
    end
    n_checks++;
    if (stall_bad != 0 || reads > 4) begin
      n_fail++;
      $display("FAIL bp_stall: got unstable_cycles=%0d reads=%0d, want 0 and <=4", stall_bad, reads);
    end
    @(posedge clka); #1;
    m_ready[1] = 1'b1;
    for (int c = 0; c < 60; c++) begin
      @(negedge clka);
      if (m_valid[1] && m_ready[1]) begin
        exp = (sb.size() > 0) ? sb.pop_front() : 9'h1xx;
        n_checks++;
        if ({m_last[1], m_gray[1]} !== exp) begin
          n_fail++;
          $display("FAIL bp_beat%0d: got last=%b gray=%0d, want last=%b gray=%0d", beats, m_last[1], m_gray[1], exp[8], exp[7:0]);
        end
        beats++;
      end
      if (done[1]) n_done++;
    end
    n_checks++;
    if (beats != 16 || sb.size() != 0 || n_done != 1) begin
      n_fail++;
      $display("FAIL bp_frame: got beats=%0d left=%0d dones=%0d, want 16 0 1", beats, sb.size(), n_done);
    end
  endtask

  task automatic test_random();
    int beats = 0, n_done = 0, tail = 0;
    bit stalled = 1'b0;
    logic [8:0] prev, exp;
    for (int i = 0; i < 64; i++) ram[2][i] = {8'(i), 8'(i), 8'(i)};
    load_sb(2, 64);
    @(posedge clka); #1;
    start[2] = 1'b1;
    @(posedge clka); #1;
    start[2] = 1'b0;
    for (int c = 0; c < 800 && tail < 5; c++) begin
      m_ready[2] = 1'($urandom_range(0, 1));
      @(negedge clka);
      if (stalled) begin
        n_checks++;
        if (m_valid[2] !== 1'b1 || {m_last[2], m_gray[2]} !== prev) begin
          n_fail++;
          $display("FAIL rand_hold: got valid=%b last=%b gray=%0d, want 1 %b %0d", m_valid[2], m_last[2], m_gray[2], prev[8], prev[7:0]);
        end
      end
      stalled = m_valid[2] && !m_ready[2];
      prev    = {m_last[2], m_gray[2]};
      if (m_valid[2] && m_ready[2]) begin
        exp = (sb.size() > 0) ? sb.pop_front() : 9'h1xx;
        n_checks++;
        if ({m_last[2], m_gray[2]} !== exp) begin
          n_fail++;
          $display("FAIL rand_beat%0d: got last=%b gray=%0d, want last=%b gray=%0d", beats, m_last[2], m_gray[2], exp[8], exp[7:0]);
        end
        beats++;
      end
      if (done[2]) n_done++;
      if (n_done > 0) tail++;
      @(posedge clka); #1;
    end
    m_ready[2] = 1'b0;
    n_checks++;
    if (beats != 64 || sb.size() != 0 || n_done != 1) begin
      n_fail++;
      $display("FAIL rand_frame: got beats=%0d left=%0d dones=%0d, want 64 0 1", beats, sb.size(), n_done);
    end
  endtask

  task automatic test_start_ignored();
    int beats = 0, n_done = 0, reads = 0;
    logic [8:0] exp;
    load_sb(0, 4);
    @(posedge clka); #1;
    m_ready[0] = 1'b1;
    start[0]   = 1'b1;
    @(posedge clka); #1;
    start[0] = 1'b0;
    for (int c = 1; c <= 25; c++) begin
      @(negedge clka);
      if (ram_ena[0]) begin
        n_checks++;
        if (ram_addra[0] !== 16'(reads)) begin
          n_fail++;
          $display("FAIL ign_addr: got addr=%0d, want %0d", ram_addra[0], reads);
        end
        reads++;
      end
      if (m_valid[0] && m_ready[0]) begin
        exp = (sb.size() > 0) ? sb.pop_front() : 9'h1xx;
        n_checks++;
        if ({m_last[0], m_gray[0]} !== exp) begin
          n_fail++;
          $display("FAIL ign_beat%0d: got last=%b gray=%0d, want last=%b gray=%0d", beats, m_last[0], m_gray[0], exp[8], exp[7:0]);
        end
        beats++;
      end
      if (c == 2) start[0] = 1'b1;
      if (done[0]) begin
        n_done++;
        start[0] = 1'b1;
      end
      @(posedge clka); #1;
      start[0] = 1'b0;
    end
    n_checks++;
    if (beats != 4 || reads != 4 || n_done != 1 || busy[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL ign_frame: got beats=%0d reads=%0d dones=%0d busy=%b, want 4 4 1 0", beats, reads, n_done, busy[0]);
    end
  endtask

  task automatic test_reset_restart();
    int beats = 0, n_done = 0;
    logic [8:0] exp;
    for (int i = 0; i < 16; i++) ram[1][i] = 24'($urandom);
    ram[1][0] = 24'h646464;
    ram[1][1] = 24'h636363;
    load_sb(1, 16);
    @(posedge clka); #1;
    m_ready[1] = 1'b1;
    start[1]   = 1'b1;
    @(posedge clka); #1;
    start[1] = 1'b0;
    for (int c = 0; c < 10 && beats < 2; c++) begin
      @(negedge clka);
      if (m_valid[1] && m_ready[1]) beats++;
    end
    @(posedge clka); #1;
    rsta = 1'b1;
    #1;
    n_checks++;
    if (beats != 2 || m_valid[1] !== 1'b0 || busy[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL rr_reset: got beats=%0d valid=%b busy=%b, want 2 0 0", beats, m_valid[1], busy[1]);
    end
    @(posedge clka); #1;
    rsta = 1'b0;
    load_sb(1, 16);
    beats = 0;
    start[1] = 1'b1;
    @(posedge clka); #1;
    start[1] = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clka);
      if (m_valid[1] && m_ready[1]) begin
        exp = (sb.size() > 0) ? sb.pop_front() : 9'h1xx;
        n_checks++;
        if ({m_last[1], m_gray[1]} !== exp) begin
          n_fail++;
          $display("FAIL rr_beat%0d: got last=%b gray=%0d, want last=%b gray=%0d", beats, m_last[1], m_gray[1], exp[8], exp[7:0]);
        end
        beats++;
      end
      if (done[1]) n_done++;
    end
    n_checks++;
    if (beats != 16 || n_done != 1) begin
      n_fail++;
      $display("FAIL rr_frame: got beats=%0d dones=%0d, want 16 1", beats, n_done);
    end
  endtask

  initial begin
    rsta = 1'b1;
    for (int k = 0; k < NI; k++) begin
      start[k]   = 1'b0;
      m_ready[k] = 1'b0;
      for (int i = 0; i < 64; i++) ram[k][i] = 24'h0;
    end
    test_reset();
    test_basic();
    test_backpressure();
    test_random();
    test_start_ignored();
    test_reset_restart();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/img_ram_gray_reader.md
Name: img_ram_gray_reader

Overview:
- Downstream consumer of the 24-bit pixel RAM (single port: clka/ena/wea/addra/dina/douta, one-cycle registered read).
- On start, scans addresses 0..NUM_PIX-1 and converts each RGB pixel to 8-bit luma.
- Streams the result on a valid/ready interface to the next processing stage.
- Never writes the RAM; it only drives the read-side port.

Parameters:
- ADDR_W, 16, RAM address width.
- DATA_W, 24, pixel width; packing is R=[23:16], G=[15:8], B=[7:0].
- NUM_PIX, 41750, pixels per frame; must be ≤ 2^ADDR_W.
- FIFO_D, 4, output buffer depth (power of two, ≥ 2).

Ports:
- clka input 1: clock, rising edge.
- rsta input 1: asynchronous active-high reset.
- start input 1: one-cycle frame request.
- busy output 1: frame in progress.
- done output 1: one-cycle pulse at frame end.
- ram_ena output 1: RAM enable (read strobe).
- ram_wea output 1: tied 0.
- ram_addra output ADDR_W: RAM read address.
- ram_douta input DATA_W: RAM read data, valid one cycle after ram_ena.
- m_valid output 1: output beat valid.
- m_ready input 1: downstream accept.
- m_gray output 8: luma value.
- m_last output 1: marks pixel NUM_PIX-1.

Behaviour:
- Clock and reset: one clock, clka. Reset rsta is asynchronous and active-high.
- Reset values: busy=0, done=0, ram_ena=0, ram_wea=0, ram_addra=0, m_valid=0, m_gray=0, m_last=0. FIFO is emptied, in-flight count=0, state=IDLE.
- IDLE:
  - start=1 → RUN; address counter cleared to 0.
  - start in any other state is ignored.
- RUN:
  - Issues a read (ram_ena=1, ram_addra=addr, addr++) whenever occupancy + inflight < FIFO_D. The pop on the same cycle is not credited.
  - After issuing addr NUM_PIX-1 → DRAIN. The counter never wraps.
  - ram_addra holds its last value when ram_ena=0.
- Read return:
  - Data is captured the cycle after issue (inflight is 0 or 1).
  - gray = (77*R + 150*G + 29*B) >> 8, computed with a 16-bit unsigned accumulator. No overflow: maximum is 65280 → 255.
  - Truncation, no rounding.
  - Pushed into the FIFO with a last flag.
- DRAIN: waits for the handshake on the m_last beat, then → DONE.
- DONE: done=1 for exactly one cycle, busy=0, → IDLE. A start in the DONE cycle is ignored.
- busy: 1 in RUN and DRAIN.
- Output handshake:
  - A beat transfers when m_valid & m_ready.
  - While m_valid=1 and m_ready=0, m_gray and m_last hold stable.
  - m_valid never drops without a transfer.
  - The FIFO head drives m_gray/m_last directly.
- Throughput: with m_ready held at 1, one beat per cycle in steady state. First beat m_valid no later than 3 cycles after start.
- Ordering: beats emerge in address order, with no loss or duplication under any m_ready pattern.
- Reset mid-frame: everything returns to reset values immediately. In-flight RAM data is discarded. The next start begins at address 0.
- m_last: asserted only on the beat for address NUM_PIX-1. m_gray is 0 whenever m_valid=0 is not required (don't-care).

Optional Feature:
- Macro: IMG_THRESH_EN.
- When defined:
  - Adds input port thresh[7:0].
  - Output becomes binary: m_gray = (gray >= thresh) ? 8'hFF : 8'h00.
  - thresh is sampled at the capture cycle of each pixel.
- When undefined: no thresh port; m_gray is raw luma. Timing and handshake are identical in both builds.

Test Plan:
1. Assert rsta mid-clock with outputs active → all outputs read 0 immediately, without waiting for a clka edge.
2. NUM_PIX=4, RAM holds FF0000, 00FF00, 0000FF, FFFFFF, m_ready=1, pulse start → m_gray 76, 149, 28, 255 on consecutive cycles. m_last only on the 255 beat. done pulses the cycle after it.
3. NUM_PIX=16, hold m_ready=0 for 10 cycles after the first m_valid → m_valid stays 1 with data stable. ram_ena stops after at most FIFO_D reads. Releasing gives all 16 values in order, none lost or duplicated.
4. Random m_ready (50%), NUM_PIX=64, RAM[i]={i,i,i} → m_gray sequence equals i (0..63) exactly. done fires once.
5. start pulsed during RUN and in the done cycle → ignored; the frame count and address sequence are unchanged.
6. Reset after 2 beats of a 16-pixel frame, then start again → the first beat is address 0 data. With IMG_THRESH_EN and thresh=100, pixels 0x646464/0x636363 → FF/00.
